balance_display_scanner: RTL and testbench
==========================================

Name: balance_display_scanner

Overview:
- Parametrised successor to the five-way balance display selector.
- Selects one of NUM_CH packed balance channels for the 8-digit seven-segment display.
- Navigation: forward and backward manual stepping, plus a timed auto-cycle mode.
- Drives the display directly with its own digit scanner and registered, tear-free value capture; sits between the account/wallet registers and the board display pins.

Parameters:
- NUM_CH, 5: number of balance channels; 2..16.
- VAL_W, 16: bits per channel value; multiple of 4, 4..28; shown as VAL_W/4 hex digits.
- SCAN_DIV, 100000: clk cycles per digit slot; must be ≥ 2.
- DWELL_CYC, 200000000: clk cycles each channel is shown in auto mode; must be ≥ 8*SCAN_DIV.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_next  in  1  debounced level; rising edge selects next channel
- btn_prev  in  1  debounced level; rising edge selects previous channel
- btn_auto  in  1  debounced level; rising edge toggles auto-cycle mode
- balances  in  NUM_CH*VAL_W  packed values; channel k at [k*VAL_W +: VAL_W]
- ch_sel  out  $clog2(NUM_CH)  currently selected channel
- auto_mode  out  1  1 = auto-cycle active
- AN  out  8  digit anodes, active-low
- led  out  7  segments a..g, active-low (bit0 = a)

Behaviour:
- Reset values: ch_sel=0, auto_mode=0, AN=8'hFF, led=7'h7F, all counters 0, button edge registers 0, captured value 0. Reset asserted mid-frame takes effect on the next clk edge.
- Edge detect: each button is registered once; a press is level & ~prev_level. Holding a button produces exactly one press.
- Channel select: next gives ch_sel = (ch_sel==NUM_CH-1) ? 0 : ch_sel+1. prev gives ch_sel = (ch_sel==0) ? NUM_CH-1 : ch_sel-1. Wrap applies for non-power-of-2 NUM_CH; ch_sel never reaches NUM_CH or above.
- Simultaneous next and prev press in the same cycle: ch_sel unchanged.
- Auto mode states: MANUAL and AUTO. A btn_auto press toggles the state, and the dwell counter is cleared on entry to AUTO.
- In AUTO, the dwell counter counts 0..DWELL_CYC-1. On the terminal count ch_sel advances as for next and the counter returns to 0.
- A manual next/prev press in AUTO steps ch_sel and clears the dwell counter.
- A dwell expiry coinciding with a manual press applies the manual press only.
- Scanner: a prescaler counts 0..SCAN_DIV-1. On its terminal count, digit index d (3 bits) increments mod 8.
- Frame capture: when d wraps 7→0, the value of channel ch_sel is copied into the captured-value register. The displayed value therefore changes only at frame boundaries, so no mixed digits appear.
- Digit content:
  - d in 0..VAL_W/4-1 shows nibble d of the captured value (digit 0 = least significant).
  - d=7 shows the captured channel index in hex, captured together with the value.
  - All other d are blanked: AN=FF, led=7F.
- Output registration: AN and led are registered and update one clk after d changes. AN = ~(1<<d) for non-blank slots. Exactly one AN bit is low at any time, or none when blanked.
- Hex encoding: 0-9, A, b, C, d, E, F, in standard active-low 7-segment form (0 → 7'b1000000, 8 → 7'b0000000, F → 7'b0001110).
- ch_sel and auto_mode are registered outputs that update on the clk edge after the press edge is detected. That is 2 clks after the button level rises.

Decomposition:
- Shared package:
  - SEG_BLANK = 7'h7F and AN_OFF = 8'hFF constants.
  - Hex-to-segment constant table.
  - Mode encoding (MANUAL=0, AUTO=1).
- One natural sub-module: seg7_hex_encode, a combinational 4-bit to 7-bit active-low encoder, reused by other display blocks.
- Edge detection, channel FSM, dwell counter, scanner and capture stay in the top module.

Test Plan (NUM_CH=5, VAL_W=16, SCAN_DIV=4, DWELL_CYC=40):
- Reset: assert reset for 3 clks during scanning -> AN=FF, led=7F, ch_sel=0, auto_mode=0 on the first clk after assertion.
- Scan and display: channel 0 = 16'h1A2F -> over one 32-clk frame, digits 0..3 show F,2,A,1 (led 0001110, 0100100, 0001000, 1111001); digit 7 shows 0; digits 4..6 blanked.
- Channel wrap: 5 btn_next pulses visit ch_sel 1,2,3,4,0. Then one btn_prev -> 4. Next and prev pulsed in the same cycle -> unchanged. A 10-clk held press -> single step.
- Auto mode: btn_auto pulse -> auto_mode=1; ch_sel advances every 40 clks (0→1→2). A btn_next at dwell count 20 -> step plus a full 40-clk dwell before the next advance. Second btn_auto -> ch_sel frozen.
- Tear-free capture: change balances[0] from 16'h1111 to 16'h2222 while d=2 -> the rest of the frame still shows 1s; the next frame shows 2s.

Source files
------------

// File: rtl/balance_display_scanner_pkg.sv
// Shared constants and types for the balance display scanner.
//   SEG_BLANK / AN_OFF : all-segments-off and all-anodes-off codes (active-low)
//   HEX_SEG            : 4-bit hex to 7-segment table, bit0 = a, active-low
//   mode_e             : channel navigation mode
package balance_display_scanner_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Entry n is the segment pattern for hex digit n (F at the top, 0 at the bottom).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

endpackage

// File: rtl/balance_display_scanner_seg7.sv
// seg7_hex_encode: combinational hex digit to active-low 7-segment encoder.
//   i_hex : 4-bit value 0..F
//   o_seg : segments a..g, active-low, bit0 = a
module seg7_hex_encode
  import balance_display_scanner_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/balance_display_scanner.sv
// balance_display_scanner: picks one of NUM_CH packed balance channels and
// multiplexes it onto an 8-digit active-low seven-segment display.
//   clk, reset          : clock, synchronous active-high reset
//   btn_next/prev/auto  : debounced button levels (rising edge = press)
//   balances            : NUM_CH packed VAL_W-bit values, channel k at [k*VAL_W +: VAL_W]
//   ch_sel, auto_mode   : selected channel, auto-cycle active
//   AN, led             : digit anodes and segments a..g, both active-low
module balance_display_scanner
  import balance_display_scanner_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int VAL_W     = 16,
  parameter int SCAN_DIV  = 100000,
  parameter int DWELL_CYC = 200000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      btn_next,
  input  logic                      btn_prev,
  input  logic                      btn_auto,
  input  logic [NUM_CH*VAL_W-1:0]   balances,
  output logic [$clog2(NUM_CH)-1:0] ch_sel,
  output logic                      auto_mode,
  output logic [7:0]                AN,
  output logic [6:0]                led
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int NDIG  = VAL_W / 4;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int DW_W  = $clog2(DWELL_CYC);

  // Buttons: bit0 next, bit1 prev, bit2 auto. r_btn_s samples the level,
  // r_btn_q holds the previous sample so a held button yields one press.
  logic [2:0]       r_btn_s, r_btn_q;
  logic [2:0]       w_press;
  logic             w_next_p, w_prev_p, w_auto_p;

  mode_e            r_mode, w_mode_nxt;
  logic [CH_W-1:0]  r_ch, w_ch_nxt, w_ch_inc, w_ch_dec;
  logic [DW_W-1:0]  r_dwell, w_dwell_nxt;

  logic [PRE_W-1:0] r_pre;
  logic             w_pre_tc;
  logic [2:0]       r_dig;
  logic [VAL_W-1:0] r_cap, w_sel_val;
  logic [CH_W-1:0]  r_cap_ch;
  logic [3:0]       w_hex;
  logic [6:0]       w_seg;
  logic             w_blank;
  logic [7:0]       r_an;
  logic [6:0]       r_led;

  assign w_press  = r_btn_s & ~r_btn_q;
  assign w_next_p = w_press[0];
  assign w_prev_p = w_press[1];
  assign w_auto_p = w_press[2];

  assign w_ch_inc = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
  assign w_ch_dec = (r_ch == '0) ? CH_W'(NUM_CH - 1) : r_ch - 1'b1;

  // Mode state register
  always_ff @(posedge clk) begin
    if (reset) r_mode <= MANUAL;
    else       r_mode <= w_mode_nxt;
  end

  // Next mode, channel and dwell count. A manual press outranks dwell expiry;
  // next+prev together cancel but still restart the dwell.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_ch_nxt    = r_ch;
    w_dwell_nxt = '0;
    if (w_auto_p) w_mode_nxt = (r_mode == MANUAL) ? AUTO : MANUAL;
    if (w_next_p && !w_prev_p)      w_ch_nxt = w_ch_inc;
    else if (w_prev_p && !w_next_p) w_ch_nxt = w_ch_dec;
    if (r_mode == AUTO && !w_auto_p) begin
      if (w_next_p || w_prev_p) begin
        w_dwell_nxt = '0;
      end else if (r_dwell == DW_W'(DWELL_CYC - 1)) begin
        w_dwell_nxt = '0;
        w_ch_nxt    = w_ch_inc;
      end else begin
        w_dwell_nxt = r_dwell + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_s <= '0;
      r_btn_q <= '0;
      r_ch    <= '0;
      r_dwell <= '0;
    end else begin
      r_btn_s <= {btn_auto, btn_prev, btn_next};
      r_btn_q <= r_btn_s;
      r_ch    <= w_ch_nxt;
      r_dwell <= w_dwell_nxt;
    end
  end

  // Scanner and frame capture: the value and its channel index are latched
  // together as d wraps 7->0, so a frame never mixes old and new digits.
  assign w_pre_tc  = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_sel_val = balances[r_ch*VAL_W +: VAL_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre    <= '0;
      r_dig    <= '0;
      r_cap    <= '0;
      r_cap_ch <= '0;
    end else begin
      r_pre <= w_pre_tc ? '0 : r_pre + 1'b1;
      if (w_pre_tc) begin
        r_dig <= r_dig + 3'd1;
        if (r_dig == 3'd7) begin
          r_cap    <= w_sel_val;
          r_cap_ch <= r_ch;
        end
      end
    end
  end

  // Digit 7 always carries the channel index; value digits above NDIG blank.
  assign w_hex   = (r_dig == 3'd7) ? 4'(r_cap_ch) : 4'(r_cap >> {r_dig, 2'b00});
  assign w_blank = (r_dig != 3'd7) && (int'(r_dig) >= NDIG);

  seg7_hex_encode u_enc (
    .i_hex (w_hex),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= AN_OFF;
      r_led <= SEG_BLANK;
    end else begin
      r_an  <= w_blank ? AN_OFF : ~(8'd1 << r_dig);
      r_led <= w_blank ? SEG_BLANK : w_seg;
    end
  end

  assign ch_sel    = r_ch;
  assign auto_mode = (r_mode == AUTO);
  assign AN        = r_an;
  assign led       = r_led;

endmodule

// File: tb/tb_balance_display_scanner.sv
module tb_balance_display_scanner;

  localparam int NUM_CH = 5, VAL_W = 16, SCAN_DIV = 4, DWELL_CYC = 40;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    btn_next = 1'b0, btn_prev = 1'b0, btn_auto = 1'b0;
  logic [NUM_CH*VAL_W-1:0] balances = '0;
  logic [2:0]              ch_sel;
  logic                    auto_mode;
  logic [7:0]              AN;
  logic [6:0]              led;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;   // clk edges since reset was released
  int f;

  balance_display_scanner #(
    .NUM_CH(NUM_CH), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV), .DWELL_CYC(DWELL_CYC)
  ) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
    .btn_auto(btn_auto), .balances(balances), .ch_sel(ch_sel),
    .auto_mode(auto_mode), .AN(AN), .led(led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic pulse_next();
    btn_next = 1'b1; step(1); btn_next = 1'b0; step(2);
  endtask

  // Digit d of the frame whose capture edge is at cycle fr is visible at fr+2+4d.
  task automatic chk_digit(input string tag, input int fr, input int d,
                           input logic [7:0] an_e, input logic [6:0] led_e);
    at_cyc(fr + 2 + 4*d);
    check({tag, "_an"}, AN, an_e);
    check({tag, "_led"}, led, led_e);
  endtask

  initial begin
    // Reset state
    step(3);
    check("rst_an", AN, 8'hFF);
    check("rst_led", led, 7'h7F);
    check("rst_ch", ch_sel, 0);
    check("rst_auto", auto_mode, 0);

    // Scan of channel 0 = 1A2F, captured at cycle 32
    balances[0 +: 16] = 16'h1A2F;
    balances[16 +: 16] = 16'h0000;
    balances[64 +: 16] = 16'h00C0;
    reset = 1'b0;
    chk_digit("d0", 32, 0, 8'hFE, 7'b0001110);
    chk_digit("d1", 32, 1, 8'hFD, 7'b0100100);
    chk_digit("d2", 32, 2, 8'hFB, 7'b0001000);
    chk_digit("d3", 32, 3, 8'hF7, 7'b1111001);
    chk_digit("d4", 32, 4, 8'hFF, 7'h7F);
    chk_digit("d5", 32, 5, 8'hFF, 7'h7F);
    chk_digit("d6", 32, 6, 8'hFF, 7'h7F);
    chk_digit("d7", 32, 7, 8'h7F, 7'b1000000);

    // Two-clock press latency, then wrap through all channels
    btn_next = 1'b1; step(1);
    check("lat_1clk", ch_sel, 0);
    btn_next = 1'b0; step(1);
    check("lat_2clk", ch_sel, 1);
    step(1);
    pulse_next(); check("next2", ch_sel, 2);
    pulse_next(); check("next3", ch_sel, 3);
    pulse_next(); check("next4", ch_sel, 4);
    pulse_next(); check("next_wrap", ch_sel, 0);
    btn_prev = 1'b1; step(1); btn_prev = 1'b0; step(2);
    check("prev_wrap", ch_sel, 4);

    // Channel-index digit and value of channel 4
    f = (cyc / 32 + 1) * 32;
    chk_digit("c4_d1", f, 1, 8'hFD, 7'b1000110);
    chk_digit("c4_d7", f, 7, 8'h7F, 7'b0011001);

    btn_next = 1'b1; btn_prev = 1'b1; step(1);
    btn_next = 1'b0; btn_prev = 1'b0; step(2);
    check("both", ch_sel, 4);
    btn_next = 1'b1; step(10); btn_next = 1'b0; step(2);
    check("held", ch_sel, 0);

    // Tear-free capture
    balances[0 +: 16] = 16'h1111;
    f = (cyc / 32 + 1) * 32;
    at_cyc(f + 9);
    balances[0 +: 16] = 16'h2222;
    chk_digit("tear_d2", f, 2, 8'hFB, 7'b1111001);
    chk_digit("tear_d3", f, 3, 8'hF7, 7'b1111001);
    chk_digit("tear_new", f + 32, 0, 8'hFE, 7'b0100100);

    // Auto mode
    btn_auto = 1'b1; step(1); btn_auto = 1'b0; step(1);
    check("auto_on", auto_mode, 1);
    step(39); check("dwell_hold0", ch_sel, 0);
    step(1);  check("dwell_adv1", ch_sel, 1);
    step(40); check("dwell_adv2", ch_sel, 2);
    step(19);
    btn_next = 1'b1; step(1); btn_next = 1'b0; step(1);
    check("auto_manual", ch_sel, 3);
    step(39); check("dwell_restart", ch_sel, 3);
    step(1);  check("dwell_adv4", ch_sel, 4);
    btn_auto = 1'b1; step(1); btn_auto = 1'b0; step(1);
    check("auto_off", auto_mode, 0);
    step(50); check("frozen", ch_sel, 4);

    // Mid-frame reset
    at_cyc(cyc + 3);
    reset = 1'b1; step(1);
    check("mrst_an", AN, 8'hFF);
    check("mrst_led", led, 7'h7F);
    check("mrst_ch", ch_sel, 0);
    check("mrst_auto", auto_mode, 0);
    step(2); reset = 1'b0; step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
